bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Per-master front end for the shared backplane arbiter.
- Accepts a single read/write command from local logic and raises one barq line toward the arbiter.
- Once granted, drives address, write data and direction onto the bus, then completes on data strobe or arbiter error.
- Returns a one-cycle response. Retries on arbiter timeout errors up to a limit, and guards against a grant that never comes.

Parameters:
- ADDR_WIDTH, 16, bus address width.
- DATA_WIDTH, 16, bus data width.
- MAX_RETRY, 3, re-requests after an arbiter error before reporting failure; 0 = no retry.
- GRANT_TIMEOUT, 64, max cycles in REQ waiting for bagd_i before abort; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target address.
- cmd_wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  DATA_WIDTH  read data; valid with rsp_valid_o on reads.
- rsp_error_o  out  1  qualifies rsp_valid_o: transfer failed.
- barq_o  out  1  bus request to arbiter.
- bagd_i  in  1  bus grant from arbiter.
- target_ready_i  in  1  arbiter target-ready.
- data_strobe_i  in  1  arbiter data strobe, one cycle.
- error_i  in  1  arbiter timeout error, one cycle.
- bus_addr_o  out  ADDR_WIDTH  address onto bus.
- bus_wdata_o  out  DATA_WIDTH  write data onto bus.
- bus_write_o  out  1  direction onto bus.
- bus_drive_o  out  1  output-enable for bus_* drivers.
- bus_rdata_i  in  DATA_WIDTH  read data from bus.

Behaviour:
- Reset (rst_n low, async): state IDLE. cmd_ready_o=1; every other output 0, including all bus_* outputs and barq_o. Retry and timeout counters = 0. Reset mid-transfer drops barq_o and bus_drive_o immediately; no response is issued.
- All outputs are registered.
- IDLE: cmd_ready_o=1. On accept, latch write/addr/wdata, clear retry_cnt, clear grant timer, go to REQ; cmd_ready_o=0 from the next cycle.
- REQ: barq_o=1; grant timer increments each cycle.
  - bagd_i=1 -> GRANTED.
  - Timer reaching GRANT_TIMEOUT with bagd_i=0 -> RESP with error; no retry.
- GRANTED: barq_o=1. bus_drive_o=1 with latched addr/wdata/write from the first cycle bagd_i is seen.
  - target_ready_i is informational only.
  - data_strobe_i=1 -> DONE_OK. On a read, capture bus_rdata_i on that same cycle.
  - error_i=1 -> DONE_ERR.
  - If data_strobe_i and error_i coincide, data_strobe_i wins.
  - bagd_i falls with neither event -> ABORT.
- ABORT: wait exactly 1 cycle. Then -> DONE_ERR, whether or not error_i arrives; the arbiter issues error one cycle after its cycle end.
- DONE_OK / DONE_ERR:
  - barq_o=0 and bus_drive_o=0 on the first cycle in these states.
  - DONE_OK -> RESP (ok).
  - DONE_ERR with retry_cnt < MAX_RETRY -> RELEASE, retry_cnt+1.
  - DONE_ERR otherwise -> RESP (error).
- RELEASE: barq_o=0. Stay until bagd_i=0 has been seen for 1 full cycle, then -> REQ with the grant timer cleared. This guarantees the arbiter re-latches the request cleanly.
- RESP: rsp_valid_o=1 for exactly one cycle, with rsp_error_o set per outcome.
  - rsp_rdata_o = captured data on a successful read, else 0.
  - -> IDLE. Also wait in RESP until bagd_i=0, holding rsp_valid_o for one cycle only, so a new request never overlaps a stale grant.
- Counters: retry_cnt width = clog2(MAX_RETRY+1), minimum 1; saturates, no wrap. Grant timer width = clog2(GRANT_TIMEOUT+1); saturates.
- No response back-pressure; the consumer must accept rsp_valid_o unconditionally.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Write 0x1234 to addr 0x00A0; arbiter grants 2 cycles after barq_o, strobe 4 cycles later -> bus_addr_o=0x00A0, bus_wdata_o=0x1234, bus_write_o=1 while granted; rsp_valid_o one pulse, rsp_error_o=0; barq_o low the cycle after the strobe.
- Read addr 0x0010, bus_rdata_i=0xBEEF only on the strobe cycle -> rsp_rdata_o=0xBEEF, rsp_error_o=0, cmd_ready_o returns to 1 after RESP.
- MAX_RETRY=3; arbiter returns error_i on the first 2 attempts, strobe on the 3rd -> exactly 3 barq_o assertions separated by >=1 cycle low; single rsp_valid_o with rsp_error_o=0.
- MAX_RETRY=3; error on every attempt -> 4 requests total, then rsp_error_o=1, rsp_rdata_o=0.
- GRANT_TIMEOUT=8, bagd_i held 0 -> barq_o high 8 cycles, then drops; rsp_valid_o with rsp_error_o=1, no retry.
- rst_n pulsed low while granted mid-transfer -> barq_o, bus_drive_o and rsp_valid_o go 0 asynchronously; after release, cmd_ready_o=1 and no response is emitted.

Source files
------------

// File: rtl/bus_master_port.sv
// ---------------------------------------------------------------------------
// bus_master_port
//
// Per-master front end for the shared backplane arbiter. It takes one
// read/write command from local logic and raises a bus request. Once the
// arbiter grants the bus, the port drives the command onto the bus and waits
// for a data strobe or an arbiter error. It then returns a one-cycle
// response. Arbiter errors are retried up to MAX_RETRY times. A grant that
// never arrives is aborted after GRANT_TIMEOUT cycles, and that case is not
// retried.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i       command present; accepted when cmd_ready_o is high
//   cmd_ready_o       high only in IDLE
//   cmd_write_i       1 = write, 0 = read
//   cmd_addr_i        target address
//   cmd_wdata_i       write data
//   rsp_valid_o       one-cycle completion pulse (no back-pressure)
//   rsp_rdata_o       read data on a successful read, else 0
//   rsp_error_o       transfer failed (qualifies rsp_valid_o)
//   barq_o            bus request to arbiter
//   bagd_i            bus grant from arbiter
//   target_ready_i    arbiter target-ready (informational, unused)
//   data_strobe_i     arbiter data strobe, one cycle
//   error_i           arbiter timeout error, one cycle
//   bus_addr_o        address onto bus
//   bus_wdata_o       write data onto bus
//   bus_write_o       direction onto bus
//   bus_drive_o       output-enable for the bus_* drivers
//   bus_rdata_i       read data from bus
//
// Every output is a flop. Each output is computed from the next state, so
// it changes on the same edge as the state it belongs to.
// ---------------------------------------------------------------------------
module bus_master_port #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_RETRY     = 3,
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  barq_o,
  input  logic                  bagd_i,
  input  logic                  target_ready_i,
  input  logic                  data_strobe_i,
  input  logic                  error_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic                  bus_write_o,
  output logic                  bus_drive_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

  // Counter widths. The retry counter is at least 1 bit wide so that
  // MAX_RETRY = 0 still yields a legal vector.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(GRANT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANTED,
    S_ABORT,
    S_DONE_OK,
    S_DONE_ERR,
    S_RELEASE,
    S_RESP
  } state_t;

  // Control state
  state_t                state_q,  state_d;
  logic                  write_q,  write_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [RW-1:0]         retry_q,  retry_d;
  logic [TW-1:0]         timer_q,  timer_d;
  logic                  fail_q,   fail_d;

  // Registered outputs
  logic                  cmd_ready_q,  cmd_ready_d;
  logic                  rsp_valid_q,  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic                  rsp_error_q,  rsp_error_d;
  logic                  barq_q,       barq_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q,   bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q,  bus_wdata_d;
  logic                  bus_write_q,  bus_write_d;
  logic                  bus_drive_q,  bus_drive_d;

  logic [TW-1:0]         timer_inc;

  // Saturating increment of the grant timer.
  assign timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    retry_d = retry_q;
    timer_d = timer_q;
    fail_d  = fail_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready_o is high exactly when we are in IDLE.
        if (cmd_valid_i) begin
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          rdata_d = '0;
          retry_d = '0;
          timer_d = '0;
          fail_d  = 1'b0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (bagd_i) begin
          state_d = S_GRANTED;
        end else begin
          timer_d = timer_inc;
          // A grant timeout is final and is not retried.
          if (timer_inc >= TIMER_LIMIT) begin
            fail_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end

      S_GRANTED: begin
        // A strobe wins over a coincident error.
        if (data_strobe_i) begin
          if (!write_q) begin
            rdata_d = bus_rdata_i;
          end
          state_d = S_DONE_OK;
        end else if (error_i) begin
          state_d = S_DONE_ERR;
        end else if (!bagd_i) begin
          state_d = S_ABORT;
        end
      end

      // The arbiter reports its error one cycle after the cycle ends, so
      // we let that cycle pass before treating the attempt as failed.
      S_ABORT: begin
        state_d = S_DONE_ERR;
      end

      S_DONE_OK: begin
        fail_d  = 1'b0;
        state_d = S_RESP;
      end

      S_DONE_ERR: begin
        if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 1'b1;
          state_d = S_RELEASE;
        end else begin
          fail_d  = 1'b1;
          state_d = S_RESP;
        end
      end

      // Keep the request low until the grant has been low for a full
      // cycle, so the arbiter sees a clean new request.
      S_RELEASE: begin
        if (!bagd_i) begin
          timer_d = '0;
          state_d = S_REQ;
        end
      end

      // Do not return to IDLE while a stale grant is still present.
      S_RESP: begin
        if (!bagd_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state (registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    barq_d      = (state_d == S_REQ) || (state_d == S_GRANTED);
    bus_drive_d = (state_d == S_GRANTED);
    bus_addr_d  = bus_drive_d ? addr_d  : '0;
    bus_wdata_d = bus_drive_d ? wdata_d : '0;
    bus_write_d = bus_drive_d ? write_d : 1'b0;

    // Pulse only on entry to RESP; RESP may be held waiting for the grant
    // to drop.
    rsp_valid_d = (state_d == S_RESP) && (state_q != S_RESP);
    rsp_error_d = rsp_valid_d && fail_d;
    rsp_rdata_d = (rsp_valid_d && !fail_d && !write_d) ? rdata_d : '0;
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      fail_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      barq_q      <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_write_q <= 1'b0;
      bus_drive_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      fail_q      <= fail_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      barq_q      <= barq_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_write_q <= bus_write_d;
      bus_drive_q <= bus_drive_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign barq_o      = barq_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_write_o = bus_write_q;
  assign bus_drive_o = bus_drive_q;

  // target_ready_i is informational only.
  logic unused_target_ready;
  assign unused_target_ready = target_ready_i;

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_wdata_i = '0;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_error_o;
  logic          barq_o;
  logic          bagd_i = 1'b0;
  logic          target_ready_i = 1'b0;
  logic          data_strobe_i = 1'b0;
  logic          error_i = 1'b0;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic          bus_write_o;
  logic          bus_drive_o;
  logic [DW-1:0] bus_rdata_i = '0;

  always #5 clk = ~clk;

  bus_master_port #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(3), .GRANT_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .barq_o(barq_o), .bagd_i(bagd_i), .target_ready_i(target_ready_i),
    .data_strobe_i(data_strobe_i), .error_i(error_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_write_o(bus_write_o),
    .bus_drive_o(bus_drive_o), .bus_rdata_i(bus_rdata_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected responses
  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int   barq_rises = 0;
  int   rsp_count  = 0;
  logic barq_prev  = 1'b0;
  logic rsp_prev   = 1'b0;

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (barq_o && !barq_prev) barq_rises++;
      if (rsp_valid_o) begin
        rsp_count++;
        if (rsp_prev) chk("rsp_pulse_width", 32'(rsp_valid_o && rsp_prev), 32'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("rsp_error", 32'(rsp_error_o), 32'(e.err));
          chk("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
          $display("rsp: error=%0d rdata=0x%04h (exp error=%0d rdata=0x%04h)",
                   rsp_error_o, rsp_rdata_o, e.err, e.rdata);
        end
      end
    end
    barq_prev = barq_o;
    rsp_prev  = rsp_valid_o;
  end

  // Transaction vectors: command, arbiter behaviour, expected outcome
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            n_err;       // attempts answered with error_i
    bit            abort_first; // first attempt ends by grant drop
    bit            coinc;       // error_i together with the strobe
    bit            no_grant;    // arbiter never grants
    int            gnt_dly;
    int            stb_dly;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_req;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input int n_err, input bit abort_first, input bit coinc,
                              input bit no_grant, input int gnt_dly, input int stb_dly,
                              input logic exp_err, input logic [DW-1:0] exp_rdata,
                              input int exp_req);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.n_err = n_err; v.abort_first = abort_first; v.coinc = coinc;
    v.no_grant = no_grant; v.gnt_dly = gnt_dly; v.stb_dly = stb_dly;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_req = exp_req;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    int  rises0;
    int  cnt;
    bit  fail_att;
    exp_t e;
    e.err = v.exp_err;
    e.rdata = v.exp_rdata;

    n = 0;
    while (!cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_before", 32'(cmd_ready_o), 32'd1);

    rises0 = barq_rises;
    sb_q.push_back(e);
    cmd_valid_i = 1'b1;
    cmd_write_i = v.wr;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    @(negedge clk);
    // Junk on the command bus afterwards must be ignored.
    cmd_valid_i = 1'b0;
    cmd_write_i = ~v.wr;
    cmd_addr_i  = AW'($urandom);
    cmd_wdata_i = DW'($urandom);

    for (int a = 0; a < v.exp_req; a++) begin
      n = 0;
      while (!barq_o && n < 20) begin @(negedge clk); n++; end
      chk("barq_raise", 32'(barq_o), 32'd1);
      if (v.no_grant) begin
        cnt = 0;
        while (barq_o && cnt < 100) begin cnt++; @(negedge clk); end
        chk("timeout_barq_cycles", 32'(cnt), 32'd8);
      end else begin
        repeat (v.gnt_dly) @(negedge clk);
        bagd_i = 1'b1;
        @(negedge clk);
        chk("bus_drive", 32'(bus_drive_o), 32'd1);
        chk("bus_addr", 32'(bus_addr_o), 32'(v.addr));
        chk("bus_wdata", 32'(bus_wdata_o), 32'(v.wdata));
        chk("bus_write", 32'(bus_write_o), 32'(v.wr));
        chk("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
        repeat (v.stb_dly - 1) @(negedge clk);
        fail_att = (a < v.n_err) || (a == 0 && v.abort_first);
        if (a == 0 && v.abort_first) begin
          bagd_i = 1'b0;
        end else if (fail_att) begin
          error_i = 1'b1;
        end else begin
          data_strobe_i = 1'b1;
          error_i       = v.coinc;
          bus_rdata_i   = v.rdata;
        end
        @(negedge clk);
        data_strobe_i = 1'b0;
        error_i       = 1'b0;
        bus_rdata_i   = '0;
        bagd_i        = 1'b0;
        chk("barq_low_after_end", 32'(barq_o), 32'd0);
        chk("drive_low_after_end", 32'(bus_drive_o), 32'd0);
      end
    end

    n = 0;
    while (sb_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
    chk("rsp_seen", 32'(sb_q.size()), 32'd0);
    n = 0;
    while (!cmd_ready_o && n < 30) begin @(negedge clk); n++; end
    chk("cmd_ready_after", 32'(cmd_ready_o), 32'd1);
    chk("request_count", 32'(barq_rises - rises0), 32'(v.exp_req));
    $display("vec %0d: wr=%0d addr=0x%04h requests=%0d (exp %0d)",
             idx, v.wr, v.addr, barq_rises - rises0, v.exp_req);
  endtask

  vec_t vecs[9];

  initial begin
    int rsp0;
    int n;

    vecs[0] = mk(1'b1, 16'h00A0, 16'h1234, 16'h0000, 0, 0, 0, 0, 2, 4, 1'b0, 16'h0000, 1);
    vecs[1] = mk(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 1, 3, 1'b0, 16'hBEEF, 1);
    vecs[2] = mk(1'b1, 16'h0F00, 16'h5A5A, 16'h0000, 2, 0, 0, 0, 1, 2, 1'b0, 16'h0000, 3);
    vecs[3] = mk(1'b0, 16'h0020, 16'h0000, 16'h7777, 99, 0, 0, 0, 1, 1, 1'b1, 16'h0000, 4);
    vecs[4] = mk(1'b1, 16'h0030, 16'h4444, 16'h0000, 0, 0, 0, 1, 0, 1, 1'b1, 16'h0000, 1);
    vecs[5] = mk(1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1, 0, 0, 0, 3, 1, 1'b0, 16'h0001, 2);
    vecs[6] = mk(1'b1, 16'h1000, 16'hCAFE, 16'h0000, 0, 1, 0, 0, 1, 2, 1'b0, 16'h0000, 2);
    vecs[7] = mk(1'b0, 16'h2000, 16'h0000, 16'h55AA, 0, 0, 1, 0, 0, 1, 1'b0, 16'h55AA, 1);
    vecs[8] = mk(1'b0, 16'h3000, 16'h0000, 16'h1111, 4, 1, 0, 0, 1, 1, 1'b1, 16'h0000, 4);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_barq", 32'(barq_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_bus", 32'({bus_drive_o, bus_write_o, bus_addr_o, bus_wdata_o} != '0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset asserted while granted: everything drops immediately and no
    // response is produced.
    rsp0 = rsp_count;
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 16'h0ABC;
    cmd_wdata_i = 16'h9999;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n = 0;
    while (!barq_o && n < 20) begin @(negedge clk); n++; end
    bagd_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_drive_before", 32'(bus_drive_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_barq", 32'(barq_o), 32'd0);
    chk("rst_mid_drive", 32'(bus_drive_o), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    bagd_i = 1'b0;
    rst_n  = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_rsp", 32'(rsp_count - rsp0), 32'd0);
    chk("rst_mid_ready_after", 32'(cmd_ready_o), 32'd1);
    chk("rst_mid_barq_after", 32'(barq_o), 32'd0);
    $display("reset mid-transfer: responses=%0d ready=%0d", rsp_count - rsp0, cmd_ready_o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
